repadd_multiplier: RTL and testbench

Sequential 16-bit unsigned multiplier that computes P = A × B by adding A into an accumulator B times. It combines a datapath (registers A, B, P, an adder, a decrementer and a zero detector) with a Moore controller that sequences the loads, the accumulation and the completion flag. Operands arrive serially on one shared input bus after a start request, and the product is available when done is asserted.

---
 rtl/repadd_multiplier_if.sv | 10 +
 rtl/repadd_multiplier.sv | 57 +++++
 tb/tb_repadd_multiplier.sv | 134 +++++++++++++
 3 files changed

// File: rtl/repadd_multiplier_if.sv
// repadd_multiplier_if: start/operand/result bus of the repeated-addition multiplier
interface repadd_multiplier_if;
  logic start;
  logic [15:0] din;
  logic [15:0] product;
  logic done;
  logic eqz;
  modport master (output start, din, input product, done, eqz);
  modport slave (input start, din, output product, done, eqz);
endinterface

// File: rtl/repadd_multiplier.sv
// repadd_multiplier: 16-bit unsigned multiply by adding A into P, B times
module repadd_multiplier (
  input logic clk,
  input logic rst_n,
  repadd_multiplier_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, ADD, DONE} state_t;
  state_t state;
  logic [15:0] a, b, p;
  logic done, ld_a, ld_b, clr_p, ld_p, dec_b;
  always_comb begin
    ld_a = state == LOAD_A;
    ld_b = state == LOAD_B;
    clr_p = state == LOAD_B;
    ld_p = state == ADD;
    dec_b = state == ADD;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a <= '0;
      b <= '0;
      p <= '0;
    end else begin
      if (ld_a) a <= bus.din;
      b <= ld_b ? bus.din : dec_b ? b - 16'd1 : b;
      p <= clr_p ? '0 : ld_p ? p + a : p;
    end
  // done is registered alongside the state so it is high exactly while in DONE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      done <= 1'b0;
    end else
      case (state)
        IDLE: if (bus.start) state <= LOAD_A;
        LOAD_A: state <= LOAD_B;
        LOAD_B: begin
          state <= bus.din == '0 ? DONE : ADD;
          done <= bus.din == '0;
        end
        ADD: begin
          state <= b == 16'd1 ? DONE : ADD;
          done <= b == 16'd1;
        end
        DONE: begin
          state <= bus.start ? DONE : IDLE;
          done <= bus.start;
        end
        default: begin
          state <= IDLE;
          done <= 1'b0;
        end
      endcase
  assign bus.product = p;
  assign bus.done = done;
  assign bus.eqz = b == '0;
endmodule

// File: tb/tb_repadd_multiplier.sv
// tb_repadd_multiplier: directed checks of latency, products, restart and async reset
module tb_repadd_multiplier;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int failures = 0;
  repadd_multiplier_if bus();
  repadd_multiplier dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  // Called just after a negedge; returns edges counted from the start-sample edge (=1) until done.
  task automatic run(input logic [15:0] av, input logic [15:0] bv, output int edges);
    bus.start = 1;
    bus.din = av;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    bus.din = av;
    @(posedge clk);
    edges++;
    @(negedge clk);
    bus.din = bv;
    @(posedge clk);
    edges++;
    @(negedge clk);
    bus.din = 16'hxxxx;
    while (bus.done !== 1'b1 && edges < 1000) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask
  task automatic to_idle();
    bus.start = 0;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic test_reset();
    bus.start = 0;
    bus.din = 16'h1234;
    repeat (2) @(negedge clk);
    checks += 3;
    if (bus.product !== 16'd0) begin failures++; $display("FAIL reset_product got=%0d exp=0", bus.product); end
    if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    if (bus.eqz !== 1'b1) begin failures++; $display("FAIL reset_eqz got=%b exp=1", bus.eqz); end
    rst_n = 1;
    @(negedge clk);
  endtask
  task automatic test_basic();
    int e;
    run(16'd8, 16'd8, e);
    checks += 3;
    if (e !== 11) begin failures++; $display("FAIL basic_latency got=%0d exp=11", e); end
    if (bus.product !== 16'd64) begin failures++; $display("FAIL basic_product got=%0d exp=64", bus.product); end
    if (bus.eqz !== 1'b1) begin failures++; $display("FAIL basic_eqz got=%b exp=1", bus.eqz); end
    bus.din = 16'd8;
    repeat (5) @(negedge clk);
    checks += 2;
    if (bus.done !== 1'b1) begin failures++; $display("FAIL basic_done_hold got=%b exp=1", bus.done); end
    if (bus.product !== 16'd64) begin failures++; $display("FAIL basic_product_hold got=%0d exp=64", bus.product); end
    to_idle();
  endtask
  task automatic test_b_zero();
    int e;
    run(16'd5, 16'd0, e);
    checks += 3;
    if (e !== 3) begin failures++; $display("FAIL bzero_latency got=%0d exp=3", e); end
    if (bus.product !== 16'd0) begin failures++; $display("FAIL bzero_product got=%0d exp=0", bus.product); end
    if (bus.eqz !== 1'b1) begin failures++; $display("FAIL bzero_eqz got=%b exp=1", bus.eqz); end
    to_idle();
  endtask
  task automatic test_a_zero();
    int e;
    run(16'd0, 16'd7, e);
    checks += 2;
    if (e !== 10) begin failures++; $display("FAIL azero_latency got=%0d exp=10", e); end
    if (bus.product !== 16'd0) begin failures++; $display("FAIL azero_product got=%0d exp=0", bus.product); end
    to_idle();
  endtask
  task automatic test_wrap();
    int e;
    run(16'd300, 16'd300, e);
    checks += 2;
    if (e !== 303) begin failures++; $display("FAIL wrap_latency got=%0d exp=303", e); end
    if (bus.product !== 16'd24464) begin failures++; $display("FAIL wrap_product got=%0d exp=24464", bus.product); end
    to_idle();
  endtask
  task automatic test_back_to_back();
    int e;
    run(16'd8, 16'd8, e);
    checks += 1;
    if (bus.product !== 16'd64) begin failures++; $display("FAIL b2b_first got=%0d exp=64", bus.product); end
    to_idle();
    checks += 2;
    if (bus.done !== 1'b0) begin failures++; $display("FAIL b2b_done_low got=%b exp=0", bus.done); end
    if (bus.product !== 16'd64) begin failures++; $display("FAIL b2b_idle_hold got=%0d exp=64", bus.product); end
    run(16'd3, 16'd4, e);
    checks += 2;
    if (e !== 7) begin failures++; $display("FAIL b2b_latency got=%0d exp=7", e); end
    if (bus.product !== 16'd12) begin failures++; $display("FAIL b2b_product got=%0d exp=12", bus.product); end
    to_idle();
  endtask
  task automatic test_reset_mid();
    int e;
    bus.start = 1;
    bus.din = 16'd8;
    repeat (6) @(negedge clk);
    checks += 1;
    if (bus.product !== 16'd24) begin failures++; $display("FAIL mid_partial got=%0d exp=24", bus.product); end
    rst_n = 0;
    #1;
    checks += 3;
    if (bus.product !== 16'd0) begin failures++; $display("FAIL mid_rst_product got=%0d exp=0", bus.product); end
    if (bus.done !== 1'b0) begin failures++; $display("FAIL mid_rst_done got=%b exp=0", bus.done); end
    if (bus.eqz !== 1'b1) begin failures++; $display("FAIL mid_rst_eqz got=%b exp=1", bus.eqz); end
    @(negedge clk);
    rst_n = 1;
    run(16'd8, 16'd8, e);
    checks += 2;
    if (e !== 11) begin failures++; $display("FAIL mid_rerun_latency got=%0d exp=11", e); end
    if (bus.product !== 16'd64) begin failures++; $display("FAIL mid_rerun_product got=%0d exp=64", bus.product); end
    to_idle();
  endtask
  initial begin
    test_reset();
    test_basic();
    test_b_zero();
    test_a_zero();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
